// File: rtl/glitch_monitor.sv
// Synchronises an asynchronous signal, debounces it, and classifies short
// excursions as glitches that are strobed and tallied in a saturating counter.
module glitch_monitor #(
    parameter int unsigned STABLE_CYC = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x_in,
    input  logic             clr_cnt,
    output logic             x_filt,
    output logic             glitch_pulse,
    output logic [CNT_W-1:0] glitch_cnt,
    output logic             cnt_sat
);

    typedef enum logic {StStable, StPending} state_e;

    localparam logic [7:0]       CommitCnt = 8'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CntMax    = '1;

    logic             s1_q, x_s_q;
    state_e           state_q, state_d;
    logic             x_filt_q, x_filt_d;
    logic [7:0]       run_cnt_q, run_cnt_d;
    logic             glitch_q, glitch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            x_s_q     <= 1'b0;
            state_q   <= StStable;
            x_filt_q  <= 1'b0;
            run_cnt_q <= '0;
            glitch_q  <= 1'b0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            s1_q      <= x_in;
            x_s_q     <= s1_q;
            state_q   <= state_d;
            x_filt_q  <= x_filt_d;
            run_cnt_q <= run_cnt_d;
            glitch_q  <= glitch_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_filt_d  = x_filt_q;
        run_cnt_d = run_cnt_q;
        glitch_d  = 1'b0;
        unique case (state_q)
            StStable: begin
                if (x_s_q != x_filt_q) begin
                    state_d   = StPending;
                    run_cnt_d = 8'd1;
                end
            end
            StPending: begin
                if (x_s_q != x_filt_q) begin
                    if (run_cnt_q == CommitCnt) begin
                        x_filt_d  = x_s_q;
                        run_cnt_d = '0;
                        state_d   = StStable;
                    end else begin
                        run_cnt_d = run_cnt_q + 8'd1;
                    end
                end else begin
                    // Reverted before the run reached commit length.
                    glitch_d  = 1'b1;
                    run_cnt_d = '0;
                    state_d   = StStable;
                end
            end
            default: state_d = StStable;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr_cnt) begin
            // A glitch coinciding with the clear is counted as the first one.
            cnt_d = glitch_d ? CNT_W'(1) : '0;
            sat_d = 1'b0;
        end else if (glitch_d) begin
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            sat_d = sat_q | (cnt_d == CntMax);
        end
    end

    assign x_filt       = x_filt_q;
    assign glitch_pulse = glitch_q;
    assign glitch_cnt   = cnt_q;
    assign cnt_sat      = sat_q;

endmodule

// File: tb/tb_glitch_monitor.sv
// Directed testbench for glitch_monitor with STABLE_CYC=4, CNT_W=4.
// Inputs change on the falling clock edge; outputs are read there as well.
module tb_glitch_monitor;

    logic       clk, rst_n, x_in, clr_cnt;
    logic       x_filt, glitch_pulse, cnt_sat;
    logic [3:0] glitch_cnt;
    int         tests_run, tests_failed, pulses_total;

    glitch_monitor #(.STABLE_CYC(4), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .x_in         (x_in),
        .clr_cnt      (clr_cnt),
        .x_filt       (x_filt),
        .glitch_pulse (glitch_pulse),
        .glitch_cnt   (glitch_cnt),
        .cnt_sat      (cnt_sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial pulses_total = 0;
    always @(negedge clk) if (glitch_pulse === 1'b1) pulses_total <= pulses_total + 1;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; x_in = 1'b0; clr_cnt = 1'b0;
        cyc(2);
        tests_run++;
        if (x_filt !== 1'b0) begin tests_failed++; $display("FAIL reset_x_filt: got %b want 0", x_filt); end
        tests_run++;
        if (glitch_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_pulse: got %b want 0", glitch_pulse); end
        tests_run++;
        if (glitch_cnt !== 4'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d want 0", glitch_cnt); end
        tests_run++;
        if (cnt_sat !== 1'b0) begin tests_failed++; $display("FAIL reset_sat: got %b want 0", cnt_sat); end
        rst_n = 1'b1;
        cyc(1);
        // Make glitch_cnt non-zero so the mid-PENDING reset is observable.
        x_in = 1'b1; cyc(1); x_in = 1'b0; cyc(6);
        tests_run++;
        if (glitch_cnt !== 4'd1) begin tests_failed++; $display("FAIL pre_reset_cnt: got %0d want 1", glitch_cnt); end
        x_in = 1'b1;
        cyc(4);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (glitch_cnt !== 4'd0 || x_filt !== 1'b0 || glitch_pulse !== 1'b0 || cnt_sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got cnt=%0d filt=%b pulse=%b sat=%b want all 0",
                     glitch_cnt, x_filt, glitch_pulse, cnt_sat);
        end
        @(negedge clk) rst_n = 1'b1;
        // x_in still 1: a fresh run from STABLE commits at edge 6, not earlier.
        cyc(5);
        tests_run++;
        if (x_filt !== 1'b0) begin tests_failed++; $display("FAIL post_reset_e5: got %b want 0", x_filt); end
        cyc(1);
        tests_run++;
        if (x_filt !== 1'b1) begin tests_failed++; $display("FAIL post_reset_e6: got %b want 1", x_filt); end
        x_in = 1'b0;
        cyc(8);
        tests_run++;
        if (x_filt !== 1'b0 || glitch_cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL post_reset_fall: got filt=%b cnt=%0d want 0/0", x_filt, glitch_cnt);
        end
    endtask

    task automatic test_held();
        int p0 = pulses_total;
        x_in = 1'b1;
        cyc(5);
        tests_run++;
        if (x_filt !== 1'b0) begin tests_failed++; $display("FAIL held_e5: got %b want 0", x_filt); end
        cyc(1);
        tests_run++;
        if (x_filt !== 1'b1) begin tests_failed++; $display("FAIL held_e6: got %b want 1", x_filt); end
        cyc(4);
        tests_run++;
        if (pulses_total - p0 !== 0 || glitch_cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL held_no_glitch: got pulses=%0d cnt=%0d want 0/0", pulses_total - p0, glitch_cnt);
        end
        x_in = 1'b0;
        cyc(8);
        tests_run++;
        if (x_filt !== 1'b0) begin tests_failed++; $display("FAIL held_fall: got %b want 0", x_filt); end
    endtask

    task automatic test_short_pulses();
        x_in = 1'b1; cyc(1); x_in = 1'b0;
        cyc(2);
        tests_run++;
        if (glitch_pulse !== 1'b0) begin tests_failed++; $display("FAIL w1_e3: got %b want 0", glitch_pulse); end
        cyc(1);
        tests_run++;
        if (glitch_pulse !== 1'b1) begin tests_failed++; $display("FAIL w1_e4: got %b want 1", glitch_pulse); end
        tests_run++;
        if (x_filt !== 1'b0) begin tests_failed++; $display("FAIL w1_filt: got %b want 0", x_filt); end
        cyc(1);
        tests_run++;
        if (glitch_pulse !== 1'b0 || glitch_cnt !== 4'd1) begin
            tests_failed++;
            $display("FAIL w1_after: got pulse=%b cnt=%0d want 0/1", glitch_pulse, glitch_cnt);
        end
        x_in = 1'b1; cyc(3); x_in = 1'b0;
        cyc(2);
        tests_run++;
        if (glitch_pulse !== 1'b0) begin tests_failed++; $display("FAIL w3_e5: got %b want 0", glitch_pulse); end
        cyc(1);
        tests_run++;
        if (glitch_pulse !== 1'b1) begin tests_failed++; $display("FAIL w3_e6: got %b want 1", glitch_pulse); end
        cyc(3);
        tests_run++;
        if (glitch_cnt !== 4'd2 || x_filt !== 1'b0) begin
            tests_failed++;
            $display("FAIL w3_cnt: got cnt=%0d filt=%b want 2/0", glitch_cnt, x_filt);
        end
    endtask

    task automatic test_boundary();
        int p0 = pulses_total;
        x_in = 1'b1; cyc(4); x_in = 1'b0;
        cyc(1);
        tests_run++;
        if (x_filt !== 1'b0) begin tests_failed++; $display("FAIL w4_e5: got %b want 0", x_filt); end
        cyc(1);
        tests_run++;
        if (x_filt !== 1'b1) begin tests_failed++; $display("FAIL w4_e6: got %b want 1", x_filt); end
        cyc(3);
        tests_run++;
        if (x_filt !== 1'b1) begin tests_failed++; $display("FAIL w4_e9: got %b want 1", x_filt); end
        cyc(1);
        tests_run++;
        if (x_filt !== 1'b0) begin tests_failed++; $display("FAIL w4_e10: got %b want 0", x_filt); end
        cyc(3);
        tests_run++;
        if (pulses_total - p0 !== 0 || glitch_cnt !== 4'd2) begin
            tests_failed++;
            $display("FAIL w4_no_glitch: got pulses=%0d cnt=%0d want 0/2", pulses_total - p0, glitch_cnt);
        end
        x_in = 1'b1;
        cyc(8);
        tests_run++;
        if (x_filt !== 1'b1) begin tests_failed++; $display("FAIL dip_pre: got %b want 1", x_filt); end
        x_in = 1'b0; cyc(1); x_in = 1'b1;
        cyc(3);
        tests_run++;
        if (glitch_pulse !== 1'b1) begin tests_failed++; $display("FAIL dip_pulse: got %b want 1", glitch_pulse); end
        cyc(2);
        tests_run++;
        if (glitch_cnt !== 4'd3 || x_filt !== 1'b1) begin
            tests_failed++;
            $display("FAIL dip_cnt: got cnt=%0d filt=%b want 3/1", glitch_cnt, x_filt);
        end
        x_in = 1'b0;
        cyc(8);
    endtask

    task automatic test_saturation();
        int p0;
        clr_cnt = 1'b1; cyc(1); clr_cnt = 1'b0;
        tests_run++;
        if (glitch_cnt !== 4'd0 || cnt_sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_first: got cnt=%0d sat=%b want 0/0", glitch_cnt, cnt_sat);
        end
        p0 = pulses_total;
        for (int i = 0; i < 16; i++) begin
            x_in = 1'b1; cyc(1); x_in = 1'b0;
            cyc(3);
            if (i == 15) begin
                tests_run++;
                if (glitch_pulse !== 1'b1) begin tests_failed++; $display("FAIL sat_strobe16: got %b want 1", glitch_pulse); end
            end
            cyc(3);
            if (i == 13) begin
                tests_run++;
                if (glitch_cnt !== 4'd14 || cnt_sat !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL sat_14: got cnt=%0d sat=%b want 14/0", glitch_cnt, cnt_sat);
                end
            end
            if (i == 14) begin
                tests_run++;
                if (glitch_cnt !== 4'd15 || cnt_sat !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL sat_15: got cnt=%0d sat=%b want 15/1", glitch_cnt, cnt_sat);
                end
            end
        end
        tests_run++;
        if (glitch_cnt !== 4'd15 || cnt_sat !== 1'b1 || pulses_total - p0 !== 16) begin
            tests_failed++;
            $display("FAIL sat_hold: got cnt=%0d sat=%b pulses=%0d want 15/1/16",
                     glitch_cnt, cnt_sat, pulses_total - p0);
        end
        clr_cnt = 1'b1; cyc(1); clr_cnt = 1'b0;
        tests_run++;
        if (glitch_cnt !== 4'd0 || cnt_sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_sat: got cnt=%0d sat=%b want 0/0", glitch_cnt, cnt_sat);
        end
        x_in = 1'b1; cyc(1); x_in = 1'b0;
        cyc(2);
        clr_cnt = 1'b1; cyc(1); clr_cnt = 1'b0;
        tests_run++;
        if (glitch_pulse !== 1'b1 || glitch_cnt !== 4'd1 || cnt_sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_coincident: got pulse=%b cnt=%0d sat=%b want 1/1/0",
                     glitch_pulse, glitch_cnt, cnt_sat);
        end
        cyc(3);
    endtask

    // x = a&b | ~b&c | d, with the ~b term lagging one 10 ns step (static-1 hazard).
    task automatic test_hazard();
        logic [3:0] vec [7];
        logic       b_prev;
        int         p0;
        vec = '{4'b1110, 4'b1010, 4'b1110, 4'b1011, 4'b1110, 4'b1010, 4'b0000};
        rst_n = 1'b0; x_in = 1'b0; cyc(1); rst_n = 1'b1;
        b_prev = 1'b1;
        p0 = pulses_total;
        for (int v = 0; v < 7; v++) begin
            for (int s = 0; s < 8; s++) begin
                x_in   = (vec[v][3] & vec[v][2]) | (~b_prev & vec[v][1]) | vec[v][0];
                b_prev = vec[v][2];
                cyc(1);
                if (v == 0 && s == 7) begin
                    tests_run++;
                    if (x_filt !== 1'b1) begin tests_failed++; $display("FAIL hazard_settle1: got %b want 1", x_filt); end
                end
            end
        end
        cyc(3);
        tests_run++;
        if (glitch_cnt !== 4'd2 || pulses_total - p0 !== 2) begin
            tests_failed++;
            $display("FAIL hazard_count: got cnt=%0d pulses=%0d want 2/2", glitch_cnt, pulses_total - p0);
        end
        tests_run++;
        if (x_filt !== 1'b0) begin tests_failed++; $display("FAIL hazard_settle0: got %b want 0", x_filt); end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst_n = 1'b0; x_in = 1'b0; clr_cnt = 1'b0;
        test_reset();
        test_held();
        test_short_pulses();
        test_boundary();
        test_saturation();
        test_hazard();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
